// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and the requantisation helper used by the
// accumulator and the later pooling/FC stages.
package cnn_pkg;

   localparam int IN_W  = 8;
   localparam int ACC_W = 16;
   localparam int OUT_W = 8;

   typedef logic [IN_W-1:0]          sum_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic [OUT_W-1:0]         pix_t;

   typedef struct packed {
      pix_t pix;
      logic sat;
   } req_t;

   localparam acc_t PIX_MAX = acc_t'((1 << OUT_W) - 1);

   // ReLU, arithmetic right shift and clamp to the unsigned pixel range;
   // sat is raised only when clamping from above.
   function automatic req_t requant(input acc_t r, input int unsigned shift);
      req_t res;
      acc_t y;
      res = '0;
      y   = r >>> shift;
      if (r[ACC_W-1]) begin
         res = '0;
      end else if (y > PIX_MAX) begin
         res.pix = '1;
         res.sat = 1'b1;
      end else begin
         res.pix = y[OUT_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/relu_requant.sv
// Combinational bias-add, ReLU, shift and saturate for one output pixel.
// Shared by any stage that turns a wide signed sum into an 8-bit pixel.
module relu_requant
   import cnn_pkg::*;
#(
   parameter int SHIFT = 2
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [IN_W-1:0]  sum,
   input  logic [ACC_W-1:0] bias,
   output logic [OUT_W-1:0] pix,
   output logic             sat
);

   logic signed [ACC_W:0] r;
   acc_t                  clamped;
   req_t                  res;

   assign r = $signed({1'b0, acc})
            + $signed({{(ACC_W+1-IN_W){1'b0}}, sum})
            + $signed({bias[ACC_W-1], bias});

   // Clamping the extra-wide sum into acc_t cannot change the result:
   // anything above the acc_t range still saturates after the shift, and
   // anything below it is negative and becomes zero through ReLU.
   always_comb begin
      clamped = r[ACC_W-1:0];
      if (r[ACC_W] != r[ACC_W-1]) begin
         clamped = r[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   assign res = requant(clamped, SHIFT);
   assign pix = res.pix;
   assign sat = res.sat;

endmodule

// File: rtl/conv_accumulator.sv
// Accumulates TERMS adder sums per output pixel, then bias/ReLU/requantises
// the result into a valid/ready output register for the pooling stage.
module conv_accumulator #(
   parameter int IN_W  = cnn_pkg::IN_W,
   parameter int ACC_W = cnn_pkg::ACC_W,
   parameter int TERMS = 9,
   parameter int SHIFT = 2,
   parameter int OUT_W = cnn_pkg::OUT_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [IN_W-1:0]  sum_in,
   input  logic             sum_valid,
   output logic             sum_ready,
   input  logic [ACC_W-1:0] bias,
   input  logic             flush,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sat_flag
);

   localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] term_cnt;
   logic             last_term;
   logic             accept;
   logic             complete;
   logic [OUT_W-1:0] new_pix;
   logic             new_sat;

   assign last_term = (term_cnt == LAST_CNT);

   // Only the completing term must wait for a free output register; earlier
   // terms keep accumulating underneath a stalled output.
   assign sum_ready = !(last_term && out_valid && !out_ready);
   assign accept    = sum_valid && sum_ready;
   assign complete  = accept && last_term && !flush;

   relu_requant #(
      .SHIFT (SHIFT)
   ) u_requant (
      .acc  (acc),
      .sum  (sum_in),
      .bias (bias),
      .pix  (new_pix),
      .sat  (new_sat)
   );

   // Partial-sum state; flush wins over any term presented in the same cycle.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         acc      <= '0;
         term_cnt <= '0;
      end else if (flush) begin
         acc      <= '0;
         term_cnt <= '0;
      end else if (accept) begin
         if (last_term) begin
            acc      <= '0;
            term_cnt <= '0;
         end else begin
            acc      <= acc + ACC_W'(sum_in);
            term_cnt <= term_cnt + 1'b1;
         end
      end
   end

   // Output register: a new pixel may replace one being handed off in the
   // same cycle, so the consumer sees back-to-back pixels with no bubble.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else if (complete) begin
         out_data  <= new_pix;
         out_valid <= 1'b1;
         if (new_sat) begin
            sat_flag <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed pixel scenarios plus a
// randomized run compared against an integer reference model.
module tb_conv_accumulator;

   localparam int TERMS = 9;
   localparam int SHIFT = 2;

   logic        Clk;
   logic        Rst;
   logic [7:0]  sum_in;
   logic        sum_valid;
   logic        sum_ready;
   logic [15:0] bias;
   logic        flush;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        sat_flag;

   int checks = 0;
   int errors = 0;

   conv_accumulator #(
      .IN_W  (8),
      .ACC_W (16),
      .TERMS (TERMS),
      .SHIFT (SHIFT),
      .OUT_W (8)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .sum_in    (sum_in),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .bias      (bias),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_flag  (sat_flag)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Hard stop in case anything in the sequence below stops advancing.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic v, input logic [7:0] s,
                                input logic signed [15:0] b, input logic f,
                                input logic o);
      sum_valid = v;
      sum_in    = s;
      bias      = b;
      flush     = f;
      out_ready = o;
   endtask

   // Presents one full pixel of identical terms, one per cycle.
   task automatic feedPixel(input logic [7:0] s, input logic signed [15:0] b,
                            input logic o);
      for (int i = 0; i < TERMS; i++) begin
         applyStimulus(1'b1, s, b, 1'b0, o);
         @(posedge Clk); #1;
      end
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, o);
   endtask

   task automatic test_reset;
      Rst = 1'b1;
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, 1'b0);
      repeat (2) @(posedge Clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid actual=%0b required=0", out_valid); end
      checks++; if (out_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_data actual=%0d required=0", out_data); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_flag actual=%0b required=0", sat_flag); end
      checks++; if (sum_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_sum_ready actual=%0b required=1", sum_ready); end
      Rst = 1'b0;
   endtask

   task automatic test_basic;
      feedPixel(8'd100, 16'sd0, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid actual=%0b required=1", out_valid); end
      checks++; if (out_data !== 8'd225) begin errors++; $display("[TB] FAIL basic_data actual=%0d required=225", out_data); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL basic_sat actual=%0b required=0", sat_flag); end
      @(posedge Clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain_valid actual=%0b required=0", out_valid); end
      checks++; if (out_data !== 8'd225) begin errors++; $display("[TB] FAIL basic_hold_data actual=%0d required=225", out_data); end
   endtask

   task automatic test_negative_bias;
      feedPixel(8'd100, -16'sd1000, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL negbias_valid actual=%0b required=1", out_valid); end
      checks++; if (out_data !== 8'd0) begin errors++; $display("[TB] FAIL negbias_data actual=%0d required=0", out_data); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL negbias_sat actual=%0b required=0", sat_flag); end
      @(posedge Clk); #1;
   endtask

   task automatic test_saturation;
      feedPixel(8'd255, 16'sd0, 1'b1);
      checks++; if (out_data !== 8'd255) begin errors++; $display("[TB] FAIL sat_data actual=%0d required=255", out_data); end
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag_set actual=%0b required=1", sat_flag); end
      @(posedge Clk); #1;
      feedPixel(8'd10, 16'sd0, 1'b1);
      checks++; if (out_data !== 8'd22) begin errors++; $display("[TB] FAIL sat_next_data actual=%0d required=22", out_data); end
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag_sticky actual=%0b required=1", sat_flag); end
      @(posedge Clk); #1;
   endtask

   task automatic test_back_to_back;
      feedPixel(8'd10, 16'sd0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd22) begin errors++; $display("[TB] FAIL bp_pixel_a actual=%0b/%0d required=1/22", out_valid, out_data); end
      for (int i = 0; i < TERMS - 1; i++) begin
         applyStimulus(1'b1, 8'd20, 16'sd0, 1'b0, 1'b0);
         #1;
         checks++; if (sum_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_early_ready term=%0d actual=%0b required=1", i, sum_ready); end
         @(posedge Clk); #1;
      end
      applyStimulus(1'b1, 8'd20, 16'sd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (sum_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready cycle=%0d actual=%0b required=0", i, sum_ready); end
         @(posedge Clk); #1;
         checks++; if (out_valid !== 1'b1 || out_data !== 8'd22) begin errors++; $display("[TB] FAIL bp_hold_a cycle=%0d actual=%0b/%0d required=1/22", i, out_valid, out_data); end
      end
      applyStimulus(1'b1, 8'd20, 16'sd0, 1'b0, 1'b1);
      #1;
      checks++; if (sum_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready actual=%0b required=1", sum_ready); end
      @(posedge Clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd45) begin errors++; $display("[TB] FAIL bp_pixel_b actual=%0b/%0d required=1/45", out_valid, out_data); end
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, 1'b1);
      @(posedge Clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_duplicate actual=%0b required=0", out_valid); end
   endtask

   task automatic test_same_cycle;
      feedPixel(8'd30, 16'sd0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd67) begin errors++; $display("[TB] FAIL same_pixel_a actual=%0b/%0d required=1/67", out_valid, out_data); end
      for (int i = 0; i < TERMS - 1; i++) begin
         applyStimulus(1'b1, 8'd40, 16'sd0, 1'b0, 1'b0);
         @(posedge Clk); #1;
      end
      applyStimulus(1'b1, 8'd40, 16'sd0, 1'b0, 1'b1);
      #1;
      checks++; if (sum_ready !== 1'b1) begin errors++; $display("[TB] FAIL same_ready actual=%0b required=1", sum_ready); end
      @(posedge Clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd90) begin errors++; $display("[TB] FAIL same_pixel_b actual=%0b/%0d required=1/90", out_valid, out_data); end
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, 1'b1);
      @(posedge Clk); #1;
   endtask

   task automatic test_flush;
      feedPixel(8'd10, 16'sd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'd50, 16'sd0, 1'b0, 1'b0);
         @(posedge Clk); #1;
      end
      applyStimulus(1'b1, 8'd50, 16'sd0, 1'b1, 1'b0);
      @(posedge Clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd22) begin errors++; $display("[TB] FAIL flush_keeps_output actual=%0b/%0d required=1/22", out_valid, out_data); end
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, 1'b1);
      @(posedge Clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drain actual=%0b required=0", out_valid); end
      feedPixel(8'd10, 16'sd0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd22) begin errors++; $display("[TB] FAIL flush_fresh_pixel actual=%0b/%0d required=1/22", out_valid, out_data); end
      @(posedge Clk); #1;
   endtask

   task automatic test_reset_midpixel;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'd50, 16'sd0, 1'b0, 1'b1);
         @(posedge Clk); #1;
      end
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, 1'b1);
      Rst = 1'b1;
      #2;
      checks++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_output actual=%0b/%0d required=0/0", out_valid, out_data); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_sat_clear actual=%0b required=0", sat_flag); end
      Rst = 1'b0;
      @(posedge Clk); #1;
      feedPixel(8'd10, 16'sd0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd22) begin errors++; $display("[TB] FAIL rstmid_fresh_pixel actual=%0b/%0d required=1/22", out_valid, out_data); end
      @(posedge Clk); #1;
   endtask

   // Randomized traffic against an integer model of the pixel rules.
   task automatic test_random;
      int  mCnt, mAcc, mData, r, y, s, tmp;
      bit  mValid, mSat, mReady, v, f, o, completed;
      logic signed [15:0] b;
      Rst = 1'b1;
      applyStimulus(1'b0, 8'd0, 16'sd0, 1'b0, 1'b0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      mCnt = 0; mAcc = 0; mData = 0; mValid = 0; mSat = 0;
      for (int i = 0; i < 1500; i++) begin
         v = ($urandom_range(9, 0) < 7);
         s = int'($urandom_range(255, 0));
         if ($urandom_range(3, 0) == 0) begin
            b = 16'($urandom);
         end else begin
            tmp = int'($urandom_range(1200, 0)) - 600;
            b = 16'(tmp);
         end
         f = ($urandom_range(19, 0) == 0);
         o = ($urandom_range(9, 0) < 6);
         applyStimulus(v, 8'(s), b, f, o);
         #1;
         mReady = !((mCnt == TERMS - 1) && mValid && !o);
         checks++; if (sum_ready !== mReady) begin errors++; $display("[TB] FAIL rand_sum_ready cycle=%0d actual=%0b required=%0b", i, sum_ready, mReady); end
         completed = 0;
         if (f) begin
            mCnt = 0;
            mAcc = 0;
         end else if (v && mReady) begin
            if (mCnt == TERMS - 1) begin
               r = mAcc + s + int'(b);
               y = (r < 0) ? 0 : (r >> SHIFT);
               if (y > 255) begin
                  mData = 255;
                  mSat  = 1;
               end else begin
                  mData = y;
               end
               mValid    = 1;
               completed = 1;
               mAcc      = 0;
               mCnt      = 0;
            end else begin
               mAcc += s;
               mCnt++;
            end
         end
         if (!completed && mValid && o) mValid = 0;
         @(posedge Clk); #1;
         checks++; if (out_valid !== mValid) begin errors++; $display("[TB] FAIL rand_out_valid cycle=%0d actual=%0b required=%0b", i, out_valid, mValid); end
         checks++; if (out_data !== 8'(mData)) begin errors++; $display("[TB] FAIL rand_out_data cycle=%0d actual=%0d required=%0d", i, out_data, mData); end
         checks++; if (sat_flag !== mSat) begin errors++; $display("[TB] FAIL rand_sat_flag cycle=%0d actual=%0b required=%0b", i, sat_flag, mSat); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative_bias();
      test_saturation();
      test_back_to_back();
      test_same_cycle();
      test_flush();
      test_reset_midpixel();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
